sha_mem_responder: RTL and testbench

- Word-addressed memory responder at the far end of the SHA core's mem_* initiator interface.
- Serves message reads from the core with 1-cycle registered latency and absorbs digest writes.
- Captures the 8-word digest window into a 256-bit register.
- Also arbitrates a host load/readback port and sequences the core's start/done handshake.

---
 rtl/sha_mem_responder_if.sv | 46 ++++
 rtl/sha_mem_responder.sv | 197 +++++++++++++++++++
 tb/tb_sha_mem_responder.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sha_mem_responder_if.sv
// Handshake/bus bundle between the SHA memory responder (slave) and its environment (master).
// Optional statistics signals exist only when SHA_MEM_RESP_STATS_EN is defined.
interface sha_mem_responder_if;
    logic         run;
    logic [15:0]  digest_addr;
    logic         core_start;
    logic         core_done;
    logic         mem_we;
    logic [15:0]  mem_addr;
    logic [31:0]  mem_write_data;
    logic [31:0]  mem_read_data;
    logic         host_req;
    logic         host_we;
    logic [15:0]  host_addr;
    logic [31:0]  host_wdata;
    logic         host_ack;
    logic [31:0]  host_rdata;
    logic         busy;
    logic [255:0] digest;
    logic         digest_valid;
    logic         oob_err;
`ifdef SHA_MEM_RESP_STATS_EN
    logic [15:0]  rd_count;
    logic [15:0]  wr_count;
`endif

    modport master (
        output run, digest_addr, core_done, mem_we, mem_addr, mem_write_data,
               host_req, host_we, host_addr, host_wdata,
        input  core_start, mem_read_data, host_ack, host_rdata, busy, digest,
               digest_valid, oob_err
`ifdef SHA_MEM_RESP_STATS_EN
             , rd_count, wr_count
`endif
    );

    modport slave (
        input  run, digest_addr, core_done, mem_we, mem_addr, mem_write_data,
               host_req, host_we, host_addr, host_wdata,
        output core_start, mem_read_data, host_ack, host_rdata, busy, digest,
               digest_valid, oob_err
`ifdef SHA_MEM_RESP_STATS_EN
             , rd_count, wr_count
`endif
    );
endinterface

// File: rtl/sha_mem_responder.sv
// Word-addressed memory responder for the SHA core: host load/readback, start/done sequencing
// and digest capture. Optional read/write counters are enabled by SHA_MEM_RESP_STATS_EN.
module sha_mem_responder #(
    parameter int          DEPTH    = 1024,
    parameter logic [31:0] OOB_DATA = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              reset,
    sha_mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] HOST     = 2'd0;
    localparam logic [1:0] ARMED    = 2'd1;
    localparam logic [1:0] WAIT_LOW = 2'd2;
    localparam logic [1:0] RUN      = 2'd3;

    logic [31:0]  mem [DEPTH];

    logic [1:0]   state_r;
    logic [1:0]   state_next_s;
    logic [1:0]   wait_cnt_r;
    logic [31:0]  mem_read_data_r;
    logic [31:0]  host_rdata_r;
    logic [15:0]  digest_addr_r;
    logic [255:0] digest_r;
    logic [7:0]   mask_r;
    logic         digest_valid_r;
    logic         oob_err_r;

    logic         served_s;
    logic         host_acc_s;
    logic [15:0]  addr_s;
    logic         in_range_s;
    logic [AW-1:0] idx_s;
    logic [31:0]  rd_word_s;
    logic         wr_en_s;
    logic [31:0]  wr_data_s;
    logic [15:0]  lane_off_s;
    logic         lane_hit_s;
    logic [7:0]   mask_next_s;

    // Host and core never access in the same state, so they share one address path.
    always_comb begin
        served_s   = (state_r != HOST);
        host_acc_s = (state_r == HOST) && bus.host_req;
        if (served_s) begin
            addr_s    = bus.mem_addr;
            wr_en_s   = bus.mem_we;
            wr_data_s = bus.mem_write_data;
        end else begin
            addr_s    = bus.host_addr;
            wr_en_s   = host_acc_s && bus.host_we;
            wr_data_s = bus.host_wdata;
        end
        in_range_s = (32'(addr_s) < 32'(DEPTH));
        idx_s      = addr_s[AW-1:0];
        if (in_range_s) begin
            rd_word_s = mem[idx_s];
        end else begin
            rd_word_s = OOB_DATA;
        end
    end

    // Digest lane decode; the 16-bit subtraction makes the window wrap modulo 2^16.
    always_comb begin
        lane_off_s  = bus.mem_addr - digest_addr_r;
        lane_hit_s  = served_s && bus.mem_we && (lane_off_s < 16'd8);
        if (lane_hit_s) begin
            mask_next_s = mask_r | (8'd1 << lane_off_s[2:0]);
        end else begin
            mask_next_s = mask_r;
        end
    end

    // Next-state logic for the host/run handshake.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            HOST: begin
                if (bus.run) begin
                    state_next_s = ARMED;
                end else begin
                    state_next_s = HOST;
                end
            end
            ARMED: state_next_s = WAIT_LOW;
            WAIT_LOW: begin
                if (!bus.core_done) begin
                    state_next_s = RUN;
                end else if (wait_cnt_r == 2'd3) begin
                    state_next_s = HOST;
                end else begin
                    state_next_s = WAIT_LOW;
                end
            end
            RUN: begin
                // Entered only with core_done low, so any high here is the rising edge.
                if (bus.core_done) begin
                    state_next_s = HOST;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: state_next_s = HOST;
        endcase
    end

    // Array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_en_s && in_range_s) begin
            mem[idx_s] <= wr_data_s;
        end
    end

    // Control state, read data registers, digest capture and error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= HOST;
            wait_cnt_r      <= 2'd0;
            mem_read_data_r <= 32'd0;
            host_rdata_r    <= 32'd0;
            digest_addr_r   <= 16'd0;
            digest_r        <= 256'd0;
            mask_r          <= 8'd0;
            digest_valid_r  <= 1'b0;
            oob_err_r       <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (state_r == WAIT_LOW) begin
                wait_cnt_r <= wait_cnt_r + 2'd1;
            end else begin
                wait_cnt_r <= 2'd0;
            end
            if (served_s) begin
                mem_read_data_r <= rd_word_s;
            end else begin
                mem_read_data_r <= 32'd0;
            end
            if (host_acc_s && !bus.host_we) begin
                host_rdata_r <= rd_word_s;
            end
            if ((served_s || host_acc_s) && !in_range_s) begin
                oob_err_r <= 1'b1;
            end
            if (state_r == HOST && bus.run) begin
                digest_addr_r  <= bus.digest_addr;
                digest_r       <= 256'd0;
                mask_r         <= 8'd0;
                digest_valid_r <= 1'b0;
            end else if (lane_hit_s) begin
                for (int i = 0; i < 8; i++) begin
                    if (lane_off_s[2:0] == 3'(i)) begin
                        digest_r[255 - 32*i -: 32] <= bus.mem_write_data;
                    end
                end
                mask_r         <= mask_next_s;
                digest_valid_r <= (mask_next_s == 8'hFF);
            end
        end
    end

    assign bus.core_start    = (state_r == ARMED);
    assign bus.busy          = served_s;
    assign bus.host_ack      = host_acc_s;
    assign bus.mem_read_data = mem_read_data_r;
    assign bus.host_rdata    = host_rdata_r;
    assign bus.digest        = digest_r;
    assign bus.digest_valid  = digest_valid_r;
    assign bus.oob_err       = oob_err_r;

`ifdef SHA_MEM_RESP_STATS_EN
    logic [15:0] rd_count_r;
    logic [15:0] wr_count_r;

    // Saturating activity counters, restarted with each run.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count_r <= 16'd0;
            wr_count_r <= 16'd0;
        end else if (state_r == HOST && bus.run) begin
            rd_count_r <= 16'd0;
            wr_count_r <= 16'd0;
        end else begin
            if (state_r == RUN && rd_count_r != 16'hFFFF) begin
                rd_count_r <= rd_count_r + 16'd1;
            end
            if (served_s && bus.mem_we && wr_count_r != 16'hFFFF) begin
                wr_count_r <= wr_count_r + 16'd1;
            end
        end
    end

    assign bus.rd_count = rd_count_r;
    assign bus.wr_count = wr_count_r;
`endif
endmodule

// File: tb/tb_sha_mem_responder.sv
// Self-checking bench for sha_mem_responder: vector tables for host/core reads scored through
// queues, plus hand-written sequences for run, timeout, digest wrap and mid-run reset.
module tb_sha_mem_responder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sha_mem_responder_if bus ();

    sha_mem_responder #(.DEPTH(1024), .OOB_DATA(32'hDEADBEEF)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [15:0] addr;
        logic [31:0] exp;
    } rd_vec_t;

    rd_vec_t     host_tab [4];
    rd_vec_t     core_tab [5];
    logic [31:0] host_q [$];
    logic [31:0] core_q [$];
    logic        host_chk, core_chk, host_pend, core_pend;
    logic [31:0] exp_h, exp_c;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: a read issued in one cycle is compared in the following cycle.
    always @(posedge clk) begin
        host_pend <= host_chk;
        core_pend <= core_chk;
    end

    always @(negedge clk) begin
        if (host_pend) begin
            if (host_q.size() == 0) begin
                chk("host_q_underflow", 256'd1, 256'd0);
            end else begin
                exp_h = host_q.pop_front();
                chk("host_rdata", 256'(bus.host_rdata), 256'(exp_h));
            end
        end
        if (core_pend) begin
            if (core_q.size() == 0) begin
                chk("core_q_underflow", 256'd1, 256'd0);
            end else begin
                exp_c = core_q.pop_front();
                chk("mem_read_data", 256'(bus.mem_read_data), 256'(exp_c));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        host_tab[0] = '{16'd5,  32'h0000_0005};
        host_tab[1] = '{16'd0,  32'h0000_0000};
        host_tab[2] = '{16'd19, 32'h0000_0013};
        host_tab[3] = '{16'd7,  32'h0000_0007};
        core_tab[0] = '{16'd3,    32'h0000_0003};
        core_tab[1] = '{16'd19,   32'h0000_0013};
        core_tab[2] = '{16'd5,    32'h0000_0005};
        core_tab[3] = '{16'd0,    32'h0000_0000};
        core_tab[4] = '{16'hFFFF, 32'hDEADBEEF};

        reset = 1'b1; host_chk = 1'b0; core_chk = 1'b0;
        bus.run = 1'b0; bus.digest_addr = 16'd0; bus.core_done = 1'b1;
        bus.mem_we = 1'b0; bus.mem_addr = 16'd0; bus.mem_write_data = 32'd0;
        bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = 16'd0; bus.host_wdata = 32'd0;
        repeat (3) tick();
        chk("rst_busy", 256'(bus.busy), 256'd0);
        chk("rst_core_start", 256'(bus.core_start), 256'd0);
        chk("rst_digest_valid", 256'(bus.digest_valid), 256'd0);
        chk("rst_oob_err", 256'(bus.oob_err), 256'd0);
        chk("rst_mem_read_data", 256'(bus.mem_read_data), 256'd0);
        chk("rst_host_rdata", 256'(bus.host_rdata), 256'd0);
        chk("rst_digest", bus.digest, 256'd0);
        reset = 1'b0;
        tick();

        // Host load of words 0..19.
        for (int i = 0; i < 20; i++) begin
            bus.host_req = 1'b1; bus.host_we = 1'b1;
            bus.host_addr = 16'(i); bus.host_wdata = 32'(i);
            #1 chk("host_wr_ack", 256'(bus.host_ack), 256'd1);
            tick();
        end
        // Host readback table.
        for (int k = 0; k < 4; k++) begin
            bus.host_we = 1'b0; bus.host_addr = host_tab[k].addr;
            host_q.push_back(host_tab[k].exp); host_chk = 1'b1;
            #1 chk("host_rd_ack", 256'(bus.host_ack), 256'd1);
            chk("host_busy", 256'(bus.busy), 256'd0);
            tick();
        end
        bus.host_req = 1'b0; host_chk = 1'b0;
        tick();

        // Run 1: normal hash with digest window at 0x20.
        bus.digest_addr = 16'h0020; bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        chk("r1_core_start_hi", 256'(bus.core_start), 256'd1);
        chk("r1_busy", 256'(bus.busy), 256'd1);
        bus.core_done = 1'b0;
        tick();
        chk("r1_core_start_lo", 256'(bus.core_start), 256'd0);
        tick();
        chk("r1_oob_clear", 256'(bus.oob_err), 256'd0);
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 16'd5;
        #1 chk("run_host_ack", 256'(bus.host_ack), 256'd0);
        tick();
        bus.host_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.mem_addr = core_tab[k].addr;
            core_q.push_back(core_tab[k].exp); core_chk = 1'b1;
            tick();
        end
        chk("oob_err_set", 256'(bus.oob_err), 256'd1);
        // Read-during-write returns old data, then the new data.
        bus.mem_addr = 16'd3; bus.mem_we = 1'b1; bus.mem_write_data = 32'h0000_0033;
        core_q.push_back(32'h0000_0003);
        tick();
        bus.mem_we = 1'b0;
        core_q.push_back(32'h0000_0033);
        tick();
        core_chk = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.mem_we = 1'b1; bus.mem_addr = 16'(16'h0020 + i);
            bus.mem_write_data = 32'(32'hA0 + i);
            tick();
            if (i == 6) chk("dv_before_8th", 256'(bus.digest_valid), 256'd0);
        end
        bus.mem_we = 1'b0; bus.mem_addr = 16'd0;
        chk("r1_digest_valid", 256'(bus.digest_valid), 256'd1);
        chk("r1_digest", bus.digest,
            256'h000000A0_000000A1_000000A2_000000A3_000000A4_000000A5_000000A6_000000A7);
        bus.core_done = 1'b1;
        tick();
        chk("r1_host_after_done", 256'(bus.busy), 256'd0);
        chk("r1_dv_hold", 256'(bus.digest_valid), 256'd1);

        // Run 2: core_done never drops, WAIT_LOW times out.
        bus.digest_addr = 16'h0030; bus.run = 1'b1;
        tick();
        bus.run = 1'b0;
        chk("r2_digest_cleared", bus.digest, 256'd0);
        chk("r2_dv_cleared", 256'(bus.digest_valid), 256'd0);
        chk("r2_oob_sticky", 256'(bus.oob_err), 256'd1);
        repeat (4) tick();
        chk("r2_still_waiting", 256'(bus.busy), 256'd1);
        tick();
        chk("r2_timeout_host", 256'(bus.busy), 256'd0);
        chk("r2_dv_zero", 256'(bus.digest_valid), 256'd0);

        // Run 3: digest window wraps past 16'hFFFF.
        bus.digest_addr = 16'hFFFA; bus.run = 1'b1;
        tick();
        bus.run = 1'b0; bus.core_done = 1'b0;
        tick(); tick();
        for (int i = 0; i < 8; i++) begin
            bus.mem_we = 1'b1; bus.mem_addr = 16'(16'hFFFA + i);
            bus.mem_write_data = 32'(32'hB0 + i);
            tick();
        end
        bus.mem_we = 1'b0; bus.mem_addr = 16'd0;
        chk("r3_digest_valid", 256'(bus.digest_valid), 256'd1);
        chk("r3_digest", bus.digest,
            256'h000000B0_000000B1_000000B2_000000B3_000000B4_000000B5_000000B6_000000B7);
        bus.core_done = 1'b1;
        tick();

        // Run 4: reset mid-run after three digest writes.
        bus.digest_addr = 16'h0040; bus.run = 1'b1;
        tick();
        bus.run = 1'b0; bus.core_done = 1'b0;
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            bus.mem_we = 1'b1; bus.mem_addr = 16'(16'h0040 + i);
            bus.mem_write_data = 32'(32'hC0 + i);
            tick();
        end
        bus.mem_we = 1'b0; bus.mem_addr = 16'd5;
        core_q.push_back(32'h0000_0005); core_chk = 1'b1;
        tick();
        core_chk = 1'b0; reset = 1'b1;
        tick();
        chk("r4_busy", 256'(bus.busy), 256'd0);
        chk("r4_core_start", 256'(bus.core_start), 256'd0);
        chk("r4_dv", 256'(bus.digest_valid), 256'd0);
        chk("r4_oob", 256'(bus.oob_err), 256'd0);
        chk("r4_mem_read_data", 256'(bus.mem_read_data), 256'd0);
        chk("r4_digest", bus.digest, 256'd0);
        reset = 1'b0; bus.core_done = 1'b1; bus.mem_addr = 16'd0;
        tick();
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 16'd5;
        host_q.push_back(32'h0000_0005); host_chk = 1'b1;
        #1 chk("r4_host_ack", 256'(bus.host_ack), 256'd1);
        tick();
        bus.host_req = 1'b0; host_chk = 1'b0;
        tick(); tick();
        chk("host_q_drained", 256'(host_q.size()), 256'd0);
        chk("core_q_drained", 256'(core_q.size()), 256'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
